// File: rtl/bc_ctrl_pkg.sv
// rtl/bc_ctrl_pkg.sv - control-word bit map, flag positions and ALU op codes shared with CU
package bc_ctrl_pkg;

    // Control word bit indices (bits 0-2 and 22-31 belong to CU alone)
    localparam int CTRL_SEQ0        = 0;
    localparam int CTRL_SEQ1        = 1;
    localparam int CTRL_SEQ2        = 2;
    localparam int CTRL_MBR_LD_MEM  = 3;
    localparam int CTRL_IR_LD       = 4;
    localparam int CTRL_MAR_LD_MBR  = 5;
    localparam int CTRL_PC_INC      = 6;
    localparam int CTRL_BR_LD       = 7;
    localparam int CTRL_ACC_CLR     = 8;
    localparam int CTRL_ACC_ADD     = 9;
    localparam int CTRL_MAR_LD_PC   = 10;
    localparam int CTRL_MEM_WE      = 11;
    localparam int CTRL_MBR_LD_ACC  = 12;
    localparam int CTRL_ACC_SUB     = 13;
    localparam int CTRL_PC_LD_MBR   = 14;
    localparam int CTRL_ACC_MUL     = 15;
    localparam int CTRL_ACC_DIV     = 16;
    localparam int CTRL_ACC_SHL     = 17;
    localparam int CTRL_ACC_SHR     = 18;
    localparam int CTRL_ACC_AND     = 19;
    localparam int CTRL_ACC_OR      = 20;
    localparam int CTRL_ACC_NOT     = 21;

    // Positions inside the 4-bit ALUflags word {ZF, CF, OF, SF}
    localparam int FLAG_SF = 0;
    localparam int FLAG_OF = 1;
    localparam int FLAG_CF = 2;
    localparam int FLAG_ZF = 3;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_CLR,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_DIV,
        ALU_SHL,
        ALU_SHR,
        ALU_AND,
        ALU_OR,
        ALU_NOT
    } alu_op_e;

endpackage

// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - single-port asynchronous-read memory bus between datapath and memory
interface datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational accumulator ALU producing result, next flags and a valid bit
module alu
    import bc_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] br,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              valid
);
    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0]            sum;
    logic [DATA_W:0]            diff;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          div_br;
    logic signed [DATA_W-1:0]   quot;
    logic                       br_zero;
    logic                       shift_ok;
    logic                       cf;
    logic                       of;

    assign sum      = {1'b0, acc} + {1'b0, br};
    assign diff     = {1'b0, acc} - {1'b0, br};
    assign prod     = $signed({{DATA_W{acc[MSB]}}, acc}) * $signed({{DATA_W{br[MSB]}}, br});
    assign br_zero  = (br == '0);
    // Divisor forced to 1 on zero so the divider never sees a zero; that result is muxed away
    assign div_br   = br_zero ? DATA_W'(1) : br;
    assign quot     = $signed(acc) / $signed(div_br);
    assign shift_ok = (br < DATA_W'(DATA_W));

    // Operation select: result plus carry/overflow for the chosen op
    always_comb begin
        result = acc;
        cf     = 1'b0;
        of     = 1'b0;
        valid  = 1'b1;
        case (op)
            ALU_CLR: result = '0;
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                cf     = sum[DATA_W];
                of     = (acc[MSB] == br[MSB]) && (sum[MSB] != acc[MSB]);
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                cf     = diff[DATA_W];
                of     = (acc[MSB] != br[MSB]) && (diff[MSB] != acc[MSB]);
            end
            ALU_MUL: begin
                result = prod[DATA_W-1:0];
                of     = (prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[MSB]}});
            end
            ALU_DIV: begin
                if (br_zero) begin
                    result = acc;
                    of     = 1'b1;
                end else if (acc == MIN_VAL && br == '1) begin
                    result = MIN_VAL;
                    of     = 1'b1;
                end else begin
                    result = quot;
                end
            end
            ALU_SHL: result = shift_ok ? (acc << br) : '0;
            ALU_SHR: result = shift_ok ? (acc >> br) : '0;
            ALU_AND: result = acc & br;
            ALU_OR:  result = acc | br;
            ALU_NOT: result = ~br;
            default: valid  = 1'b0;
        endcase
    end

    // Flag word assembled from the new result
    always_comb begin
        flags          = '0;
        flags[FLAG_ZF] = (result == '0);
        flags[FLAG_CF] = cf;
        flags[FLAG_OF] = of;
        flags[FLAG_SF] = result[MSB];
    end
endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - BitCruncher register-transfer datapath driven by the CU control word
module datapath
    import bc_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Control_Signals,
    output logic [7:0]        IR_out,
    output logic [3:0]        ALUflags,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    datapath_if.master        bus
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mbr;
    logic [7:0]        ir;
    logic [DATA_W-1:0] br;
    logic [DATA_W-1:0] acc;
    logic [3:0]        flags;

    alu_op_e           op;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              alu_valid;

    // Bits owned by CU only; kept visible so their absence here is deliberate
    logic unused_ctrl;
    assign unused_ctrl = ^{Control_Signals[31:22], Control_Signals[CTRL_SEQ2:CTRL_SEQ0]};

    // Fixed-priority pick of the single ACC operation for this cycle
    always_comb begin
        op = ALU_NONE;
        if      (Control_Signals[CTRL_ACC_CLR]) op = ALU_CLR;
        else if (Control_Signals[CTRL_ACC_ADD]) op = ALU_ADD;
        else if (Control_Signals[CTRL_ACC_SUB]) op = ALU_SUB;
        else if (Control_Signals[CTRL_ACC_MUL]) op = ALU_MUL;
        else if (Control_Signals[CTRL_ACC_DIV]) op = ALU_DIV;
        else if (Control_Signals[CTRL_ACC_SHL]) op = ALU_SHL;
        else if (Control_Signals[CTRL_ACC_SHR]) op = ALU_SHR;
        else if (Control_Signals[CTRL_ACC_AND]) op = ALU_AND;
        else if (Control_Signals[CTRL_ACC_OR])  op = ALU_OR;
        else if (Control_Signals[CTRL_ACC_NOT]) op = ALU_NOT;
    end

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .acc    (acc),
        .br     (br),
        .result (alu_result),
        .flags  (alu_flags),
        .valid  (alu_valid)
    );

    // Register transfers; each bit takes effect at the edge that ends its cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            mar   <= '0;
            mbr   <= '0;
            ir    <= '0;
            br    <= '0;
            acc   <= '0;
            flags <= 4'b1000;
        end else begin
            if (Control_Signals[CTRL_MBR_LD_MEM])
                mbr <= bus.mem_rdata;
            else if (Control_Signals[CTRL_MBR_LD_ACC])
                mbr <= acc;

            if (Control_Signals[CTRL_IR_LD])
                ir <= mbr[DATA_W-1:ADDR_W];

            if (Control_Signals[CTRL_MAR_LD_PC])
                mar <= pc;
            else if (Control_Signals[CTRL_MAR_LD_MBR])
                mar <= mbr[ADDR_W-1:0];

            if (Control_Signals[CTRL_PC_LD_MBR])
                pc <= mbr[ADDR_W-1:0];
            else if (Control_Signals[CTRL_PC_INC])
                pc <= pc + ADDR_W'(1);

            if (Control_Signals[CTRL_BR_LD])
                br <= mbr;

            if (alu_valid) begin
                acc   <= alu_result;
                flags <= alu_flags;
            end
        end
    end

    assign bus.mem_addr  = mar;
    assign bus.mem_wdata = mbr;
    assign bus.mem_we    = Control_Signals[CTRL_MEM_WE];

    assign IR_out   = ir;
    assign ALUflags = flags;
    assign acc_out  = acc;
    assign pc_out   = pc;
endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed and randomized check of datapath against an arithmetic reference model
module tb_datapath;
    import bc_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic [7:0]  ir_out;
    logic [3:0]  alu_flags;
    logic [15:0] acc_out;
    logic [7:0]  pc_out;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    int m_pc, m_mar, m_mbr, m_ir, m_br, m_acc, m_fl;

    datapath_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    assign bus.mem_rdata = mem[bus.mem_addr];

    datapath #(
        .DATA_W (16),
        .ADDR_W (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Control_Signals (ctrl),
        .IR_out          (ir_out),
        .ALUflags        (alu_flags),
        .acc_out         (acc_out),
        .pc_out          (pc_out),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cbit(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // ACC operation semantics in plain integer arithmetic
    task automatic alu_model(input logic [31:0] c, input int acc, input int br,
                             output bit valid, output int res, output int fl);
        int sa, sb, full, p;
        bit cy, ov;
        sa = to_signed16(acc);
        sb = to_signed16(br);
        cy = 0;
        ov = 0;
        full = 0;
        valid = 1;
        if (c[CTRL_ACC_CLR]) full = 0;
        else if (c[CTRL_ACC_ADD]) begin
            full = acc + br;
            cy = (full > 65535);
            ov = (sa + sb > 32767) || (sa + sb < -32768);
        end else if (c[CTRL_ACC_SUB]) begin
            full = acc - br;
            cy = (acc < br);
            ov = (sa - sb > 32767) || (sa - sb < -32768);
        end else if (c[CTRL_ACC_MUL]) begin
            p = sa * sb;
            full = p;
            ov = (p > 32767) || (p < -32768);
        end else if (c[CTRL_ACC_DIV]) begin
            if (br == 0) begin
                full = acc;
                ov = 1;
            end else if (sa == -32768 && sb == -1) begin
                full = 32768;
                ov = 1;
            end else begin
                full = sa / sb;
            end
        end else if (c[CTRL_ACC_SHL]) full = (br >= 16) ? 0 : (acc << br);
        else if (c[CTRL_ACC_SHR]) full = (br >= 16) ? 0 : (acc >> br);
        else if (c[CTRL_ACC_AND]) full = acc & br;
        else if (c[CTRL_ACC_OR])  full = acc | br;
        else if (c[CTRL_ACC_NOT]) full = ~br;
        else valid = 0;
        res = full & 'hFFFF;
        fl = ((res == 0) ? 8 : 0) + (cy ? 4 : 0) + (ov ? 2 : 0) + ((res >= 32768) ? 1 : 0);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc_out,        m_pc);
        check({tag, ".mar"},   bus.mem_addr,  m_mar);
        check({tag, ".mbr"},   bus.mem_wdata, m_mbr);
        check({tag, ".ir"},    ir_out,        m_ir);
        check({tag, ".acc"},   acc_out,       m_acc);
        check({tag, ".flags"}, alu_flags,     m_fl);
    endtask

    // One clock cycle with control word c; model advances alongside the DUT
    task automatic step(input logic [31:0] c, input string tag);
        logic        we_s;
        logic [7:0]  a_s;
        logic [15:0] d_s;
        bit v;
        int res, fl;
        int n_pc, n_mar, n_mbr, n_ir, n_br, n_acc, n_fl;
        ctrl = c;
        #1;
        check({tag, ".mem_we"}, bus.mem_we, c[CTRL_MEM_WE]);
        we_s = bus.mem_we;
        a_s  = bus.mem_addr;
        d_s  = bus.mem_wdata;
        alu_model(c, m_acc, m_br, v, res, fl);
        n_mbr = c[CTRL_MBR_LD_MEM] ? int'(mem[m_mar]) : (c[CTRL_MBR_LD_ACC] ? m_acc : m_mbr);
        n_ir  = c[CTRL_IR_LD] ? (m_mbr / 256) : m_ir;
        n_mar = c[CTRL_MAR_LD_PC] ? m_pc : (c[CTRL_MAR_LD_MBR] ? (m_mbr % 256) : m_mar);
        n_pc  = c[CTRL_PC_LD_MBR] ? (m_mbr % 256) : (c[CTRL_PC_INC] ? ((m_pc + 1) % 256) : m_pc);
        n_br  = c[CTRL_BR_LD] ? m_mbr : m_br;
        n_acc = v ? res : m_acc;
        n_fl  = v ? fl : m_fl;
        @(posedge clk);
        #1;
        if (we_s) mem[a_s] = d_s;
        m_pc = n_pc; m_mar = n_mar; m_mbr = n_mbr; m_ir = n_ir;
        m_br = n_br; m_acc = n_acc; m_fl = n_fl;
        check_all(tag);
    endtask

    task automatic put_mbr(input int v);
        mem[m_mar] = 16'(v);
        step(cbit(CTRL_MBR_LD_MEM), "put_mbr");
    endtask

    task automatic set_br(input int v);
        put_mbr(v);
        step(cbit(CTRL_BR_LD), "set_br");
    endtask

    task automatic set_acc(input int v);
        set_br(v);
        step(cbit(CTRL_ACC_CLR), "set_acc_clr");
        step(cbit(CTRL_ACC_ADD), "set_acc_add");
    endtask

    initial begin
        rst  = 1'b1;
        ctrl = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0; m_br = 0; m_acc = 0; m_fl = 8;
        check("rst_pc", pc_out, 0);
        check("rst_acc", acc_out, 0);
        check("rst_flags", alu_flags, 4'b1000);
        check_all("rst");
        step(cbit(CTRL_PC_INC), "inc");
        check("inc_pc", pc_out, 1);

        // Fetch
        put_mbr(16'h0003);
        step(cbit(CTRL_PC_LD_MBR), "ld_pc");
        check("fetch_pc", pc_out, 3);
        mem[3] = 16'h0210;
        step(cbit(CTRL_MAR_LD_PC), "f1");
        step(cbit(CTRL_MBR_LD_MEM), "f2");
        step(cbit(CTRL_IR_LD) | cbit(CTRL_MAR_LD_MBR), "f3");
        check("fetch_ir", ir_out, 8'h02);
        check("fetch_mar", bus.mem_addr, 8'h10);

        // Add with carry, then subtract with borrow
        set_acc(16'hFFFF);
        set_br(16'h0001);
        step(cbit(CTRL_ACC_ADD), "add");
        check("add_acc", acc_out, 16'h0000);
        check("add_flags", alu_flags, 4'b1100);
        step(cbit(CTRL_ACC_SUB), "sub");
        check("sub_acc", acc_out, 16'hFFFF);
        check("sub_flags", alu_flags, 4'b0101);

        // Divide corner cases
        set_acc(16'h8000);
        set_br(16'hFFFF);
        step(cbit(CTRL_ACC_DIV), "div_min");
        check("div_min_acc", acc_out, 16'h8000);
        check("div_min_of", alu_flags[FLAG_OF], 1);
        set_br(0);
        step(cbit(CTRL_ACC_DIV), "div_zero");
        check("div_zero_acc", acc_out, 16'h8000);
        check("div_zero_of", alu_flags[FLAG_OF], 1);
        set_acc(7);
        set_br(16'hFFFE);
        step(cbit(CTRL_ACC_DIV), "div_neg");
        check("div_neg_acc", acc_out, 16'hFFFD);

        // Shifts and NOT
        set_acc(16'h00F0);
        set_br(4);
        step(cbit(CTRL_ACC_SHL), "shl");
        check("shl_acc", acc_out, 16'h0F00);
        set_br(16);
        step(cbit(CTRL_ACC_SHR), "shr16");
        check("shr16_acc", acc_out, 0);
        check("shr16_zf", alu_flags[FLAG_ZF], 1);
        set_br(16'h0F0F);
        step(cbit(CTRL_ACC_NOT), "not");
        check("not_acc", acc_out, 16'hF0F0);
        check("not_sf", alu_flags[FLAG_SF], 1);

        // Priorities and store
        set_acc(5);
        step(cbit(CTRL_ACC_CLR) | cbit(CTRL_ACC_ADD), "clr_add");
        check("clr_add_acc", acc_out, 0);
        check("clr_add_flags", alu_flags, 4'b1000);
        put_mbr(16'h0042);
        step(cbit(CTRL_PC_INC) | cbit(CTRL_PC_LD_MBR), "pc_prio");
        check("pc_prio_pc", pc_out, 8'h42);
        set_acc(16'h1234);
        step(cbit(CTRL_MBR_LD_ACC), "st1");
        step(cbit(CTRL_MEM_WE), "st2");
        check("store_mem", mem[m_mar], 16'h1234);
        put_mbr(16'h00FF);
        step(cbit(CTRL_PC_LD_MBR), "pc_ff");
        check("pc_ff", pc_out, 8'hFF);
        step(cbit(CTRL_PC_INC), "pc_wrap");
        check("pc_wrap", pc_out, 0);

        // Randomized control words against the model
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] c;
            if (i % 8 == 0) c = $urandom;
            else c = $urandom & $urandom & $urandom;
            step(c, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/datapath.md
# datapath

Register-transfer datapath of the BitCruncher accumulator CPU, directly downstream of the microprogrammed control unit `CU`. Each cycle it applies the 32-bit `Control_Signals` word from `CU` to its registers (PC, MAR, MBR, IR, BR, ACC) and to the ALU. It returns the opcode (`IR_out`) and the registered ALU flags (`ALUflags`) to `CU`. It also drives a single-port asynchronous-read data/instruction memory.

## Interface
- `DATA_W`, default 16: width of MBR, BR, ACC and memory words; instruction = {opcode[7:0], address[ADDR_W-1:0]}.
- `ADDR_W`, default 8: width of PC, MAR and memory address; DATA_W = 8 + ADDR_W is required.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Control_Signals` in 32: the control word from `CU`, bit meanings listed under Operation.
- `IR_out` out 8: the IR register, routed to `CU.IR_in`.
- `ALUflags` out 4: registered flags {ZF, CF, OF, SF} = bits [3:0]; routed to `CU.ALUflags`.
- `mem_addr` out ADDR_W: equal to MAR.
- `mem_wdata` out DATA_W: equal to MBR.
- `mem_we` out 1: equal to C11; combinational.
- `mem_rdata` in DATA_W: asynchronous read data at `mem_addr`.
- `acc_out` out DATA_W: the ACC register, for debug and display.
- `pc_out` out ADDR_W: the PC register, for debug.

## Operation
- Bits C0–C2 are consumed by `CU` only and are ignored here, as are bits 22–31.
- MBR: C3 loads `mem_rdata`; C12 loads ACC (the value before this edge). If both are set, C3 wins.
- IR: C4 loads MBR[DATA_W-1:ADDR_W].
- MAR: C10 loads PC; C5 loads MBR[ADDR_W-1:0]. If both are set, C10 wins.
- PC: C14 loads MBR[ADDR_W-1:0]; C6 increments PC modulo 2^ADDR_W, so 0xFF becomes 0x00. If both are set, C14 wins.
- BR: C7 loads MBR.
- Memory write: C11 drives `mem_we`=1; the memory writes MBR to MAR at the edge.
- ACC operations, one per cycle. Fixed priority if several are set: C8 > C9 > C13 > C15 > C16 > C17 > C18 > C19 > C20 > C21.
  - C8: ACC=0.
  - C9: ACC+BR. C13: ACC−BR.
  - C15: ACC*BR, signed, low DATA_W bits kept.
  - C16: ACC/BR, signed, truncates toward 0.
  - C17: ACC<<BR. C18: ACC>>BR, logical. A shift amount of BR ≥ DATA_W gives 0.
  - C19: ACC&BR. C20: ACC|BR. C21: ~BR.
- Flags update only on cycles where an ACC operation executes; otherwise they hold.
  - ZF and SF are taken from the new ACC value.
  - CF: carry-out on add, borrow on sub; 0 for every other operation.
  - OF, add/sub: signed overflow.
  - OF, multiply: set if the 2·DATA_W signed product differs from the sign-extension of its low half.
  - OF, divide: set on divide-by-zero (ACC unchanged) and on MIN/−1 (ACC=MIN).
  - OF: 0 for every other operation.
  - C8 sets flags = 4'b1000.

## Timing
- On `rst`=1 at a clock edge:
  - PC, MAR, MBR, IR, BR and ACC all become 0.
  - `ALUflags` becomes 4'b1000 (ZF=1).
  - `mem_we` follows C11 combinationally and is not gated by reset.
- Reset mid-instruction discards all state; `CU` is reset in the same cycle.
- Every register transfer has a latency of 1 cycle: the control bit is set in cycle n and the value is visible after edge n.
- Flags for an operation in cycle n are valid from cycle n+1. This matches `CU` sampling flags one microstep after the ALU step.
- Reads return the same cycle: with MAR stable, C3 captures `mem_rdata` at the next edge.

## Structure
- Shared package/header `bc_ctrl_pkg` holds:
  - the `CTRL_*` bit index constants (0–21);
  - the flag positions `FLAG_SF`=0, `FLAG_OF`=1, `FLAG_CF`=2, `FLAG_ZF`=3.
  - `CU` uses the same package.
- One sub-module, `alu`: purely combinational. Inputs: operation select, ACC, BR. Outputs: result, next flags, and a `valid` bit that is set when the operation is an ACC operation.
- The registers and priority muxes live in `datapath`.

## Test plan
- Reset: drive `rst`=1 for 2 cycles → all registers read 0 and `ALUflags`=4'b1000. Then assert C6 once → `pc_out`=1.
- Fetch: PC=3, memory[3]=16'h0210. Sequence C10; C3; C4 and C5 in one cycle → `IR_out`=8'h02, `mem_addr`=8'h10.
- Add with carry: ACC=16'hFFFF, BR=16'h0001, C9 → ACC=0, flags {ZF,CF,OF,SF}=4'b1100. Then C13 with BR=1 → ACC=16'hFFFF, flags=4'b0101.
- Divide: ACC=16'h8000, BR=16'hFFFF, C16 → ACC=16'h8000, OF=1. Then BR=0, C16 → ACC unchanged, OF=1. Then ACC=7, BR=16'hFFFE (−2), C16 → ACC=16'hFFFD.
- Shift/logic: ACC=16'h00F0.
  - BR=4, C17 → 16'h0F00.
  - BR=16, C18 → 0 with ZF=1.
  - BR=16'h0F0F, C21 → 16'hF0F0 with SF=1.
- Priorities and store:
  - C8 and C9 together → ACC=0.
  - C6 and C14 together with MBR=16'h0042 → PC=16'h42.
  - ACC=16'h1234, C12, then C11 → `mem_we`=1 and memory[MAR]=16'h1234.
  - PC=8'hFF with C6 → PC=0.
